// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART definitions: clocking constants common with the baud-rate
// generator and the receive FSM state encoding.
package uart_rx_ctrl_pkg;

  localparam int CLK       = 50_000_000;
  localparam int BAUD_RATE = 240_000;
  localparam int NUM_TICKS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  // Clocks between oversampling ticks for a given line rate (13 at the defaults).
  function automatic int baud_div(input int clk_hz, input int baud, input int ticks);
    return clk_hz / (baud * ticks);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; both flops reset to
// RST_VAL so the output is quiet while the system comes out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: sequences the 16x oversampling ticks, samples each bit at
// mid-bit and delivers one byte per frame with a framing-error flag.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s to fall
// START | counting to the middle of the start bit to confirm it
// DATA  | sampling data bits LSB first, one per N_TICKS ticks
// STOP  | waiting to mid-stop-bit, then publishing byte and stop-bit status
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int N_DATA       = 8,
  parameter int N_TICKS      = NUM_TICKS,
  parameter int N_STOP_TICKS = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ticks,
  input  logic              rx,
  output logic [N_DATA-1:0] dout,
  output logic              rx_done,
  output logic              frame_err
);

  localparam int S_MAX = (N_TICKS > N_STOP_TICKS) ? N_TICKS : N_STOP_TICKS;
  localparam int S_W   = $clog2(S_MAX);
  localparam int N_W   = (N_DATA > 1) ? $clog2(N_DATA) : 1;

  localparam logic [S_W-1:0] S_HALF = S_W'(N_TICKS / 2 - 1);
  localparam logic [S_W-1:0] S_FULL = S_W'(N_TICKS - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(N_STOP_TICKS - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(N_DATA - 1);

  logic rx_s;

  state_t            state, state_n;
  logic [S_W-1:0]    s_cnt, s_cnt_n;
  logic [N_W-1:0]    n_cnt, n_cnt_n;
  logic [N_DATA-1:0] b, b_n;
  logic [N_DATA-1:0] dout_n;
  logic              rx_done_n, frame_err_n;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      s_cnt     <= '0;
      n_cnt     <= '0;
      b         <= '0;
      dout      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      s_cnt     <= s_cnt_n;
      n_cnt     <= n_cnt_n;
      b         <= b_n;
      dout      <= dout_n;
      rx_done   <= rx_done_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    s_cnt_n     = s_cnt;
    n_cnt_n     = n_cnt;
    b_n         = b;
    dout_n      = dout;
    frame_err_n = frame_err;
    rx_done_n   = 1'b0;
    case (state)
      // Start edge is taken without waiting for a tick; a coincident tick is not counted.
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_cnt_n = '0;
        end
      end
      START: begin
        if (ticks) begin
          if (s_cnt == S_HALF) begin
            if (!rx_s) begin
              state_n = DATA;
              s_cnt_n = '0;
              n_cnt_n = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_cnt_n = s_cnt + S_W'(1);
          end
        end
      end
      DATA: begin
        if (ticks) begin
          if (s_cnt == S_FULL) begin
            s_cnt_n = '0;
            b_n     = {rx_s, b[N_DATA-1:1]};
            if (n_cnt == N_LAST) state_n = STOP;
            else                 n_cnt_n = n_cnt + N_W'(1);
          end else begin
            s_cnt_n = s_cnt + S_W'(1);
          end
        end
      end
      // Leaves mid-stop-bit so a back-to-back start edge is never missed.
      STOP: begin
        if (ticks) begin
          if (s_cnt == S_STOP) begin
            dout_n      = b;
            frame_err_n = ~rx_s;
            rx_done_n   = 1'b1;
            state_n     = IDLE;
          end else begin
            s_cnt_n = s_cnt + S_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: tick-timed serialiser, scoreboard of expected
// (byte, frame_err) pairs and directed plus random frame sequences.
module tb_uart_rx_ctrl;
  import uart_rx_ctrl_pkg::*;

  localparam int TICK_DIV = 13;
  localparam int BIT_T    = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ticks = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] dout;
  logic       rx_done;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int done_cyc  = 0;
  int tcnt      = 0;
  logic tick_en = 1'b1;
  logic prev_done = 1'b0;
  logic [8:0] exp_q[$];
  logic [8:0] e;

  uart_rx_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .ticks     (ticks),
    .rx        (rx),
    .dout      (dout),
    .rx_done   (rx_done),
    .frame_err (frame_err)
  );

  always #10 clock = ~clock;

  // Stand-in for the baud-rate generator: one tick every TICK_DIV clocks, freezable.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (tick_en) begin
      if (tcnt == TICK_DIV - 1) begin
        tcnt  <= 0;
        ticks <= 1'b1;
      end else begin
        tcnt  <= tcnt + 1;
        ticks <= 1'b0;
      end
    end else begin
      ticks <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (rx_done) begin
      chk("done_width", 32'(prev_done), 0);
      chk("done_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("dout", 32'(dout), 32'(e[7:0]));
        chk("frame_err", 32'(frame_err), 32'(e[8]));
      end
      done_cyc = cyc;
    end
    prev_done = rx_done;
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      do begin
        @(posedge clock);
        guard++;
      end while (!ticks && guard < 2000);
      if (!ticks) begin
        failures++;
        $display("FAIL tick_timeout got=0 exp=1");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "tick stream stopped");
      end
    end
  endtask

  task automatic send_bit(input logic v, input int n);
    @(negedge clock);
    rx = v;
    wait_ticks(n);
  endtask

  // A bad stop bit is held low for only 12 ticks: long enough to be sampled
  // mid-bit, short enough that the receiver's re-arm sees the line high again.
  task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int gap, input bit expect_done);
    if (expect_done) exp_q.push_back({~stop_ok, data});
    @(negedge clock);
    start_cyc = cyc;
    rx = 1'b0;
    wait_ticks(BIT_T);
    for (int i = 0; i < 8; i++) send_bit(data[i], BIT_T);
    if (stop_ok) begin
      send_bit(1'b1, BIT_T);
    end else begin
      send_bit(1'b0, 12);
      send_bit(1'b1, 4);
    end
    if (gap > 0) send_bit(1'b1, gap);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(posedge clock);
      guard++;
    end
    chk(tag, 32'(exp_q.size()), 0);
  endtask

  initial begin
    int lat;
    repeat (5) @(negedge clock);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_done", 32'(rx_done), 0);
    chk("rst_err", 32'(frame_err), 0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    @(negedge clock);
    reset = 1'b0;
    wait_ticks(4);

    // nominal byte and its latency from the start edge
    send_frame(8'hA5, 1'b1, 4, 1'b1);
    drain("nominal_drain");
    lat = done_cyc - start_cyc;
    chk("nominal_latency", 32'(lat >= 1960 && lat <= 1995), 1);

    // back-to-back, no idle gap
    send_frame(8'h00, 1'b1, 0, 1'b1);
    send_frame(8'hFF, 1'b1, 0, 1'b1);
    send_frame(8'h3C, 1'b1, 4, 1'b1);
    drain("b2b_drain");

    // glitch rejection
    @(negedge clock);
    rx = 1'b0;
    repeat (39) @(negedge clock);
    rx = 1'b1;
    wait_ticks(2 * 10 * BIT_T);
    chk("glitch_state", 32'(dut.state), 32'(IDLE));
    send_frame(8'h5A, 1'b1, 4, 1'b1);
    drain("glitch_drain");

    // framing error then a clean frame
    send_frame(8'h81, 1'b0, 8, 1'b1);
    drain("ferr_drain");
    send_frame(8'h42, 1'b1, 4, 1'b1);
    drain("ferr_clean_drain");

    // asynchronous reset during data bit 4
    fork
      send_frame(8'hF0, 1'b1, 0, 1'b0);
      begin
        wait_ticks(84);
        @(negedge clock);
        #7 reset = 1'b1;
        #1;
        chk("midrst_dout", 32'(dout), 0);
        chk("midrst_err", 32'(frame_err), 0);
        chk("midrst_done", 32'(rx_done), 0);
      end
    join
    @(negedge clock);
    reset = 1'b0;
    wait_ticks(4);
    send_frame(8'h99, 1'b1, 4, 1'b1);
    drain("postrst_drain");

    // tick gating in the middle of data bit 4
    fork
      send_frame(8'h77, 1'b1, 4, 1'b1);
      begin
        wait_ticks(84);
        @(negedge clock);
        tick_en = 1'b0;
        chk("gate_state_a", 32'(dut.state), 32'(DATA));
        chk("gate_ncnt_a", 32'(dut.n_cnt), 4);
        chk("gate_scnt_a", 32'(dut.s_cnt), 12);
        repeat (500) @(negedge clock);
        chk("gate_state_b", 32'(dut.state), 32'(DATA));
        chk("gate_ncnt_b", 32'(dut.n_cnt), 4);
        chk("gate_scnt_b", 32'(dut.s_cnt), 12);
        tick_en = 1'b1;
      end
    join
    drain("gate_drain");

    // random frames, random stop-bit quality and gaps
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      bit ok;
      int gap;
      d   = 8'($urandom);
      ok  = ($urandom_range(0, 3) != 0);
      gap = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : 0;
      send_frame(d, ok, gap, 1'b1);
    end
    wait_ticks(8);
    drain("random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
